// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state and master-id types for the data-memory arbiter
package dmem_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   typedef enum logic {M_CPU = 1'b0, M_DMA = 1'b1} master_e;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin chooser
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  master_e    last_grant,
   output logic       valid,
   output master_e    grant_id
);
   // A lone request wins outright; on a tie the master not served last wins
   always_comb begin
      valid    = |req;
      grant_id = master_e'((req == 2'b11) ? ~last_grant : req[1]);
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU and DMA accesses onto the single-port dmem with wait states
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   output logic                  cpu_stall,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic [DATA_WIDTH-1:0] dma_rdata,
   output logic                  dma_ack,
   output logic                  dma_stall,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   state_e                state_q;
   master_e               gnt_q, last_q, pick_id;
   logic                  pick_valid, we_q, cpu_ack_q, dma_ack_q;
   logic [CW-1:0]         cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, cpu_rdata_q, dma_rdata_q;

   rr_pick2 u_pick (
      .req       ({dma_req, cpu_req}),
      .last_grant(last_q),
      .valid     (pick_valid),
      .grant_id  (pick_id)
   );

   // Arbitration FSM: latch the winner in IDLE, count wait states in BUSY, pulse ack in DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= M_CPU;
         last_q      <= M_DMA;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
         case (state_q)
            IDLE: if (pick_valid) begin
               gnt_q   <= pick_id;
               we_q    <= (pick_id == M_DMA) ? dma_we : cpu_we;
               addr_q  <= (pick_id == M_DMA) ? dma_addr : cpu_addr;
               wdata_q <= (pick_id == M_DMA) ? dma_wdata : cpu_wdata;
               cnt_q   <= CW'(WAIT_CYCLES);
               state_q <= BUSY;
            end
            BUSY: if (cnt_q == '0) begin
               if (gnt_q == M_DMA) begin
                  dma_rdata_q <= mem_rdata;
                  dma_ack_q   <= 1'b1;
               end else begin
                  cpu_rdata_q <= mem_rdata;
                  cpu_ack_q   <= 1'b1;
               end
               last_q  <= gnt_q;
               state_q <= DONE;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Write strobe only in the last BUSY cycle so each store writes exactly once
   always_comb begin
      mem_we    = (state_q == BUSY) && (cnt_q == '0) && we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      cpu_ack   = cpu_ack_q;
      dma_ack   = dma_ack_q;
      cpu_rdata = cpu_rdata_q;
      dma_rdata = dma_rdata_q;
      cpu_stall = cpu_req & ~cpu_ack_q;
      dma_stall = dma_req & ~dma_ack_q;
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors, corner sequences and randomized traffic for dmem_arbiter
module tb_dmem_arbiter;
   localparam int W = 2;

   logic        clk = 1'b0, reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_ack, cpu_stall, dma_ack, dma_stall, mem_we;
   logic [31:0] ram [64] = '{default: 32'd0};

   logic        w0_req = 1'b0;
   logic [31:0] w0_addr = '0, w0_rd = '0;
   logic [31:0] w0_cpu_rdata, w0_dma_rdata, w0_mem_addr, w0_mem_wdata;
   logic        w0_cpu_ack, w0_cpu_stall, w0_dma_ack, w0_dma_stall, w0_mem_we;

   int n_chk = 0, n_fail = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rdata = ram[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

   dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_stall(dma_stall),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset),
      .cpu_req(w0_req), .cpu_we(1'b0), .cpu_addr(w0_addr), .cpu_wdata(32'd0),
      .cpu_rdata(w0_cpu_rdata), .cpu_ack(w0_cpu_ack), .cpu_stall(w0_cpu_stall),
      .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'd0), .dma_wdata(32'd0),
      .dma_rdata(w0_dma_rdata), .dma_ack(w0_dma_ack), .dma_stall(w0_dma_stall),
      .mem_we(w0_mem_we), .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata), .mem_rdata(w0_rd)
   );

   // ctl = {reset, cpu_req, cpu_we, dma_req, dma_we}; e = {mem_we, cpu_ack, dma_ack, cpu_stall, dma_stall}
   // rs selects an rdata check: 1 = cpu_rdata, 2 = dma_rdata
   typedef struct {
      logic [4:0]  ctl;
      logic [31:0] a, d;
      logic [4:0]  e;
      logic [1:0]  rs;
      logic [31:0] erd;
   } vec_t;
   vec_t tv[$];

   task automatic add(input logic [4:0] ctl, input logic [31:0] a, d, input logic [4:0] e,
                      input logic [1:0] rs, input logic [31:0] erd);
      tv.push_back('{ctl, a, d, e, rs, erd});
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic        rq[2], rw[2];
   logic [31:0] ra[2], rd[2], ref_mem[64];
   int          issued[2], done_n[2], t_raise[2], gap[2];
   int          stores, we_seen, lat, k;
   logic        ack_m;
   logic [31:0] rdat_m;

   initial begin
      // WAIT_CYCLES = 0: a load takes one BUSY cycle and returns that cycle's memory data
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      w0_req = 1'b1; w0_addr = 32'h40; w0_rd = 32'h1111_0000;
      @(negedge clk);
      chk("w0_c0_ack", w0_cpu_ack, 0);
      chk("w0_c0_stall", w0_cpu_stall, 1);
      @(posedge clk); #1 w0_rd = 32'hABCD_1234;
      @(negedge clk);
      chk("w0_c1_ack", w0_cpu_ack, 0);
      chk("w0_c1_stall", w0_cpu_stall, 1);
      chk("w0_c1_mem_we", w0_mem_we, 0);
      chk("w0_c1_addr", w0_mem_addr, 32'h40);
      @(posedge clk); #1 w0_req = 1'b0; w0_rd = 32'h5555_5555;
      @(negedge clk);
      chk("w0_c2_ack", w0_cpu_ack, 1);
      chk("w0_c2_rdata", w0_cpu_rdata, 32'hABCD_1234);
      @(posedge clk); #1;
      @(negedge clk);
      chk("w0_c3_ack", w0_cpu_ack, 0);

      // CPU store 0x54 <- 88
      add(5'b10000, 0, 0, 5'b00000, 0, 0);
      repeat (3) add(5'b01100, 32'h54, 88, 5'b00010, 0, 0);
      add(5'b01100, 32'h54, 88, 5'b10010, 0, 0);
      add(5'b00000, 0, 0, 5'b01000, 0, 0);
      // DMA load 0x54
      repeat (4) add(5'b00010, 32'h54, 0, 5'b00001, 0, 0);
      add(5'b00000, 0, 0, 5'b00100, 2'd2, 88);
      // simultaneous requests after reset: CPU first, DMA after
      add(5'b10000, 0, 0, 5'b00000, 0, 0);
      repeat (4) add(5'b01010, 32'h54, 0, 5'b00011, 0, 0);
      add(5'b00010, 32'h54, 0, 5'b01001, 2'd1, 88);
      repeat (4) add(5'b00010, 32'h54, 0, 5'b00001, 0, 0);
      add(5'b00000, 0, 0, 5'b00100, 2'd2, 88);
      // reset during the second BUSY cycle of a store, then a fresh store
      repeat (2) add(5'b01100, 32'h20, 32'h77, 5'b00010, 0, 0);
      add(5'b10000, 0, 0, 5'b00000, 0, 0);
      add(5'b00000, 0, 0, 5'b00000, 0, 0);
      repeat (3) add(5'b01100, 32'h24, 32'h55, 5'b00010, 0, 0);
      add(5'b01100, 32'h24, 32'h55, 5'b10010, 0, 0);
      add(5'b00000, 0, 0, 5'b01000, 0, 0);

      foreach (tv[i]) begin
         @(posedge clk); #1;
         {reset, cpu_req, cpu_we, dma_req, dma_we} = tv[i].ctl;
         cpu_addr = tv[i].a; dma_addr = tv[i].a; cpu_wdata = tv[i].d; dma_wdata = tv[i].d;
         @(negedge clk);
         chk($sformatf("v%0d_mem_we", i), mem_we, tv[i].e[4]);
         chk($sformatf("v%0d_cpu_ack", i), cpu_ack, tv[i].e[3]);
         chk($sformatf("v%0d_dma_ack", i), dma_ack, tv[i].e[2]);
         chk($sformatf("v%0d_cpu_stall", i), cpu_stall, tv[i].e[1]);
         chk($sformatf("v%0d_dma_stall", i), dma_stall, tv[i].e[0]);
         if (tv[i].e[4]) begin
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].a);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tv[i].d);
         end
         if (tv[i].rs == 2'd1) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tv[i].erd);
         if (tv[i].rs == 2'd2) chk($sformatf("v%0d_dma_rdata", i), dma_rdata, tv[i].erd);
      end
      chk("ram_store_done", ram[21], 88);
      chk("ram_aborted_store", ram[8], 0);
      chk("ram_store_after_reset", ram[9], 32'h55);

      // both masters requesting continuously: grants alternate, acks every 5 cycles
      @(posedge clk); #1 reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0; cpu_addr = 32'h54; dma_addr = 32'h24;
      k = 0;
      for (int t = 0; t < 26; t++) begin
         @(negedge clk);
         if (cpu_ack | dma_ack) begin
            chk($sformatf("b2b_ack%0d_cycle", k), t, 4 + 5 * k);
            chk($sformatf("b2b_ack%0d_is_dma", k), dma_ack, k % 2);
            chk($sformatf("b2b_ack%0d_excl", k), cpu_ack & dma_ack, 0);
            k++;
         end
         @(posedge clk); #1;
      end
      chk("b2b_ack_count", k, 5);

      // randomized traffic against a memory/ordering reference model
      cpu_req = 1'b0; dma_req = 1'b0; reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      foreach (ref_mem[i]) ref_mem[i] = ram[i];
      stores = 0; we_seen = 0;
      for (int m = 0; m < 2; m++) begin
         rq[m] = 1'b0; rw[m] = 1'b0; ra[m] = '0; rd[m] = '0;
         issued[m] = 0; done_n[m] = 0; t_raise[m] = 0; gap[m] = $urandom_range(0, 3);
      end
      for (int t = 0; t < 700; t++) begin
         @(negedge clk);
         if (mem_we) we_seen++;
         chk("rnd_cpu_stall", cpu_stall, rq[0] & ~cpu_ack);
         chk("rnd_dma_stall", dma_stall, rq[1] & ~dma_ack);
         chk("rnd_ack_excl", cpu_ack & dma_ack, 0);
         for (int m = 0; m < 2; m++) begin
            ack_m  = m ? dma_ack : cpu_ack;
            rdat_m = m ? dma_rdata : cpu_rdata;
            if (ack_m) begin
               chk($sformatf("rnd_m%0d_ack_pending", m), rq[m], 1);
               lat = cyc - t_raise[m];
               if (lat < W + 2 || lat > 2 * W + 5) chk($sformatf("rnd_m%0d_latency", m), lat, W + 2);
               else n_chk++;
               if (rw[m]) begin
                  ref_mem[ra[m][7:2]] = rd[m];
                  chk($sformatf("rnd_m%0d_store", m), ram[ra[m][7:2]], rd[m]);
                  stores++;
               end else begin
                  chk($sformatf("rnd_m%0d_load", m), rdat_m, ref_mem[ra[m][7:2]]);
               end
               done_n[m]++;
               rq[m] = 1'b0;
               gap[m] = $urandom_range(0, 3);
            end else if (!rq[m]) begin
               if (gap[m] > 0) gap[m]--;
               else if (t < 600) begin
                  rq[m] = 1'b1;
                  rw[m] = 1'($urandom_range(0, 1));
                  ra[m] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                  rd[m] = $urandom;
                  t_raise[m] = cyc;
                  issued[m]++;
               end
            end
         end
         cpu_req = rq[0]; cpu_we = rw[0]; cpu_addr = ra[0]; cpu_wdata = rd[0];
         dma_req = rq[1]; dma_we = rw[1]; dma_addr = ra[1]; dma_wdata = rd[1];
      end
      chk("rnd_cpu_all_served", done_n[0], issued[0]);
      chk("rnd_dma_all_served", done_n[1], issued[1]);
      chk("rnd_write_count", we_seen, stores);
      chk("rnd_had_traffic", (issued[0] > 10 && issued[1] > 10) ? 1 : 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (dmem) between two requesters: the CPU load/store port (master 0) and a DMA/debug loader port (master 1).
- Serialises accesses, inserts WAIT_CYCLES memory wait states and uses round-robin priority on ties.
- Drives a per-master stall so the processor freezes while its access is pending.
- Sits between the cpu/loader and dmem inside computer.

Parameters:
- ADDR_WIDTH, 32, byte address width passed through to dmem.
- DATA_WIDTH, 32, data word width.
- WAIT_CYCLES, 2, extra memory wait states per access (0 legal).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request; held until cpu_ack.
- cpu_we  input  1  CPU write enable (1 = store, 0 = load).
- cpu_addr  input  ADDR_WIDTH  CPU byte address.
- cpu_wdata  input  DATA_WIDTH  CPU store data.
- cpu_rdata  output  DATA_WIDTH  CPU load data; valid while cpu_ack.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_stall  output  1  cpu_req & ~cpu_ack (combinational).
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same as cpu_*, for master 1.
- mem_we  output  1  dmem write enable.
- mem_addr  output  ADDR_WIDTH  dmem address.
- mem_wdata  output  DATA_WIDTH  dmem write data.
- mem_rdata  input  DATA_WIDTH  dmem combinational read data.

Behaviour:
- Reset:
  - state = IDLE.
  - cpu_ack = dma_ack = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata regs = 0.
  - last_grant = DMA, so the CPU wins the first tie.
  - Reset asserted mid-operation forces all of the above immediately. The pending transaction is dropped, with no write and no ack.
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - Requests are sampled at the rising edge.
  - If only one req is high, grant it.
  - If both are high, grant the master not equal to last_grant.
  - On grant, latch grant id, we, addr and wdata; set cnt = WAIT_CYCLES; go to BUSY.
  - If neither req is high, stay in IDLE.
- BUSY:
  - mem_addr and mem_wdata are driven from the latched registers.
  - Lasts WAIT_CYCLES+1 cycles; cnt decrements each cycle.
  - mem_we = latched we only in the final BUSY cycle (cnt == 0), giving exactly one write per store.
  - At the edge ending the final cycle: capture mem_rdata into the granted master's rdata reg, set that master's ack = 1, update last_grant, go to DONE.
- DONE:
  - The granted master's ack is high for exactly this cycle; ack is registered.
  - Next state is IDLE.
  - The master must drop req by the end of the DONE cycle; a req still high in the following IDLE is a new request.
- Latency: req visible in IDLE at cycle 0 -> BUSY in cycles 1..WAIT_CYCLES+1 -> ack in cycle WAIT_CYCLES+2 (4 for the default).
- Inputs change while granted: addr/we/wdata changes are ignored (latched). Dropping req mid-transaction does not abort; the access completes and the ack still pulses.
- Ungranted master: its req stays pending and its stall stays high. It cannot be starved, since it wins the next tie.
- rdata: holds its last captured value between acks; undefined meaning for writes (it still captures mem_rdata).
- cnt width: max(1, $clog2(WAIT_CYCLES+1)).
- mem_we is never high outside BUSY.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - master id enum {M_CPU = 0, M_DMA = 1}.
- Sub-module rr_pick2: combinational two-way round-robin chooser.
  - Inputs: req[1:0], last_grant.
  - Outputs: valid, grant_id.
- The top module holds the FSM, counter and latches.

Test Plan:
- Reset, then CPU store addr 0x54, data 88 (WAIT_CYCLES=2) -> mem_we high only in cycle 3 with mem_addr 0x54 and mem_wdata 88; cpu_ack in cycle 4; dmem RAM[21] = 88; cpu_stall high in cycles 0-3.
- DMA load addr 0x54 after the above -> dma_ack in cycle 4 with dma_rdata = 88; mem_we stays 0 throughout.
- cpu_req and dma_req rise together right after reset -> CPU granted first (ack cycle 4); IDLE in cycle 5; DMA BUSY in cycles 6-8; dma_ack in cycle 9; dma_stall high in cycles 0-8.
- Both masters hold continuous back-to-back requests -> grants alternate CPU, DMA, CPU, DMA; each ack is 5 cycles after the previous one.
- Reset asserted in the second BUSY cycle of a CPU store -> mem_we and cpu_ack drop to 0 immediately; the write never occurs; after release, the next req is served normally with a fresh 4-cycle latency.
- Instance with WAIT_CYCLES=0, CPU load -> a single BUSY cycle (cycle 1); cpu_ack in cycle 2 carrying the mem_rdata value from cycle 1.
